// File: rtl/spr_bus_access_ctrl.sv
// SPR bus master: turns single mtspr/mfspr requests into strobed bus cycles
// to the DMMU/IMMU/DC/IC groups, with local completion and a no-ack watchdog.
module spr_bus_access_ctrl #(
  parameter int OPTION_OPERAND_WIDTH = 32,
  parameter int OPTION_SPR_TIMEOUT   = 64
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            req_valid_i,
  input  logic                            req_we_i,
  input  logic [15:0]                     req_addr_i,
  input  logic [OPTION_OPERAND_WIDTH-1:0] req_dat_i,
  output logic                            req_ready_o,
  output logic                            resp_valid_o,
  output logic [OPTION_OPERAND_WIDTH-1:0] resp_dat_o,
  output logic                            resp_err_o,
  output logic [15:0]                     spr_bus_addr_o,
  output logic                            spr_bus_we_o,
  output logic                            spr_bus_stb_o,
  output logic [OPTION_OPERAND_WIDTH-1:0] spr_bus_dat_o,
  input  logic                            spr_bus_ack_dmmu_i,
  input  logic                            spr_bus_ack_immu_i,
  input  logic                            spr_bus_ack_dc_i,
  input  logic                            spr_bus_ack_ic_i,
  input  logic [OPTION_OPERAND_WIDTH-1:0] spr_bus_dat_dmmu_i,
  input  logic [OPTION_OPERAND_WIDTH-1:0] spr_bus_dat_immu_i,
  input  logic [OPTION_OPERAND_WIDTH-1:0] spr_bus_dat_dc_i,
  input  logic [OPTION_OPERAND_WIDTH-1:0] spr_bus_dat_ic_i
);

  localparam int W   = OPTION_OPERAND_WIDTH;
  localparam int WDW = (OPTION_SPR_TIMEOUT > 1) ? $clog2(OPTION_SPR_TIMEOUT) : 1;
  localparam logic [WDW-1:0] WDOG_LAST =
    WDW'((OPTION_SPR_TIMEOUT > 0) ? OPTION_SPR_TIMEOUT - 1 : 0);
  localparam bit WDOG_EN = (OPTION_SPR_TIMEOUT > 0);

  typedef enum logic [1:0] {IDLE, BUS, RESP} state_t;

  state_t         state_reg;
  logic [3:0]     grp_sel_reg;
  logic [WDW-1:0] wdog_reg;
  logic [15:0]    bus_addr_reg;
  logic           bus_we_reg;
  logic           bus_stb_reg;
  logic [W-1:0]   bus_dat_reg;
  logic           resp_valid_reg;
  logic [W-1:0]   resp_dat_reg;
  logic           resp_err_reg;

  logic [3:0]     grp_dec;
  logic [3:0]     ack_vec;
  logic [W-1:0]   slv_dat [4];
  logic [W-1:0]   slv_dat_masked [4];
  logic [W-1:0]   sel_dat;
  logic           sel_ack;

  assign ack_vec    = {spr_bus_ack_ic_i, spr_bus_ack_dc_i, spr_bus_ack_immu_i, spr_bus_ack_dmmu_i};
  assign slv_dat[0] = spr_bus_dat_dmmu_i;
  assign slv_dat[1] = spr_bus_dat_immu_i;
  assign slv_dat[2] = spr_bus_dat_dc_i;
  assign slv_dat[3] = spr_bus_dat_ic_i;

  always_comb begin
    grp_dec = 4'b0000;
    case (req_addr_i[15:11])
      5'd1:    grp_dec = 4'b0001;
      5'd2:    grp_dec = 4'b0010;
      5'd3:    grp_dec = 4'b0100;
      5'd4:    grp_dec = 4'b1000;
      default: grp_dec = 4'b0000;
    endcase
  end

  // One-hot AND-OR read mux; only the captured group can contribute.
  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_dat_mask
      assign slv_dat_masked[gi] = grp_sel_reg[gi] ? slv_dat[gi] : '0;
    end
  endgenerate

  always_comb begin
    sel_dat = '0;
    for (int i = 0; i < 4; i++) sel_dat = sel_dat | slv_dat_masked[i];
  end

  assign sel_ack     = |(grp_sel_reg & ack_vec);
  assign req_ready_o = (state_reg == IDLE) & ~rst;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg      <= IDLE;
      grp_sel_reg    <= 4'b0000;
      wdog_reg       <= '0;
      bus_addr_reg   <= '0;
      bus_we_reg     <= 1'b0;
      bus_stb_reg    <= 1'b0;
      bus_dat_reg    <= '0;
      resp_valid_reg <= 1'b0;
      resp_dat_reg   <= '0;
      resp_err_reg   <= 1'b0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (req_valid_i) begin
            if (|grp_dec) begin
              bus_addr_reg <= req_addr_i;
              bus_we_reg   <= req_we_i;
              bus_dat_reg  <= req_dat_i;
              bus_stb_reg  <= 1'b1;
              grp_sel_reg  <= grp_dec;
              wdog_reg     <= '0;
              state_reg    <= BUS;
            end else begin
              resp_valid_reg <= 1'b1;
              resp_dat_reg   <= '0;
              resp_err_reg   <= 1'b0;
              state_reg      <= RESP;
            end
          end
        end
        BUS: begin
          // Ack takes priority over a coincident watchdog expiry.
          if (sel_ack && bus_stb_reg) begin
            bus_stb_reg    <= 1'b0;
            bus_we_reg     <= 1'b0;
            resp_valid_reg <= 1'b1;
            resp_dat_reg   <= bus_we_reg ? '0 : sel_dat;
            resp_err_reg   <= 1'b0;
            state_reg      <= RESP;
          end else if (WDOG_EN && wdog_reg == WDOG_LAST) begin
            bus_stb_reg    <= 1'b0;
            bus_we_reg     <= 1'b0;
            resp_valid_reg <= 1'b1;
            resp_dat_reg   <= '0;
            resp_err_reg   <= 1'b1;
            state_reg      <= RESP;
          end else begin
            wdog_reg <= wdog_reg + 1'b1;
          end
        end
        RESP: begin
          resp_valid_reg <= 1'b0;
          state_reg      <= IDLE;
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  assign resp_valid_o   = resp_valid_reg;
  assign resp_dat_o     = resp_dat_reg;
  assign resp_err_o     = resp_err_reg;
  assign spr_bus_addr_o = bus_addr_reg;
  assign spr_bus_we_o   = bus_we_reg;
  assign spr_bus_stb_o  = bus_stb_reg;
  assign spr_bus_dat_o  = bus_dat_reg;

endmodule

// File: tb/tb_spr_bus_access_ctrl.sv
// Directed bench for spr_bus_access_ctrl; inputs change and outputs are
// sampled on the falling clock edge.
module tb_spr_bus_access_ctrl;

  localparam int W = 32;

  logic         clk = 1'b0;
  logic         rst;
  logic         req_valid_i, req_we_i;
  logic [15:0]  req_addr_i;
  logic [W-1:0] req_dat_i;
  logic         req_ready_o, resp_valid_o, resp_err_o;
  logic [W-1:0] resp_dat_o;
  logic [15:0]  spr_bus_addr_o;
  logic         spr_bus_we_o, spr_bus_stb_o;
  logic [W-1:0] spr_bus_dat_o;
  logic         ack_dmmu, ack_immu, ack_dc, ack_ic;
  logic [W-1:0] dat_dmmu, dat_immu, dat_dc, dat_ic;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  spr_bus_access_ctrl #(.OPTION_OPERAND_WIDTH(W), .OPTION_SPR_TIMEOUT(8)) dut (
    .clk(clk), .rst(rst),
    .req_valid_i(req_valid_i), .req_we_i(req_we_i), .req_addr_i(req_addr_i),
    .req_dat_i(req_dat_i), .req_ready_o(req_ready_o),
    .resp_valid_o(resp_valid_o), .resp_dat_o(resp_dat_o), .resp_err_o(resp_err_o),
    .spr_bus_addr_o(spr_bus_addr_o), .spr_bus_we_o(spr_bus_we_o),
    .spr_bus_stb_o(spr_bus_stb_o), .spr_bus_dat_o(spr_bus_dat_o),
    .spr_bus_ack_dmmu_i(ack_dmmu), .spr_bus_ack_immu_i(ack_immu),
    .spr_bus_ack_dc_i(ack_dc), .spr_bus_ack_ic_i(ack_ic),
    .spr_bus_dat_dmmu_i(dat_dmmu), .spr_bus_dat_immu_i(dat_immu),
    .spr_bus_dat_dc_i(dat_dc), .spr_bus_dat_ic_i(dat_ic)
  );

  // Present a request at a falling edge; accepted on the next rising edge.
  task automatic issue(input logic we, input logic [15:0] addr, input logic [W-1:0] dat);
    @(negedge clk);
    checks++;
    if (req_ready_o !== 1'b1) begin
      errors++;
      $display("FAIL issue_ready addr=%h got=%b exp=1", addr, req_ready_o);
    end
    req_valid_i = 1'b1; req_we_i = we; req_addr_i = addr; req_dat_i = dat;
    @(negedge clk);
    req_valid_i = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    checks++;
    if (spr_bus_stb_o !== 1'b0 || spr_bus_we_o !== 1'b0 || spr_bus_addr_o !== 16'h0 ||
        spr_bus_dat_o !== '0 || resp_valid_o !== 1'b0 || resp_dat_o !== '0 || resp_err_o !== 1'b0) begin
      errors++;
      $display("FAIL reset_outputs got stb=%b we=%b addr=%h dat=%h rv=%b rd=%h re=%b exp all zero",
               spr_bus_stb_o, spr_bus_we_o, spr_bus_addr_o, spr_bus_dat_o, resp_valid_o, resp_dat_o, resp_err_o);
    end
    checks++;
    if (req_ready_o !== 1'b0) begin
      errors++;
      $display("FAIL reset_ready_in_rst got=%b exp=0", req_ready_o);
    end
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if (req_ready_o !== 1'b1) begin
      errors++;
      $display("FAIL reset_ready_after got=%b exp=1", req_ready_o);
    end
    $display("test_reset done");
  endtask

  task automatic test_write_dmmu();
    issue(1'b1, 16'h0800, 32'hDEADBEEF);
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (spr_bus_stb_o !== 1'b1 || spr_bus_addr_o !== 16'h0800 || spr_bus_we_o !== 1'b1 ||
          spr_bus_dat_o !== 32'hDEADBEEF || req_ready_o !== 1'b0 || resp_valid_o !== 1'b0) begin
        errors++;
        $display("FAIL wr_bus_hold cyc=%0d got stb=%b addr=%h we=%b dat=%h rdy=%b rv=%b exp 1/0800/1/deadbeef/0/0",
                 i, spr_bus_stb_o, spr_bus_addr_o, spr_bus_we_o, spr_bus_dat_o, req_ready_o, resp_valid_o);
      end
      if (i == 3) ack_dmmu = 1'b1;
      @(negedge clk);
    end
    ack_dmmu = 1'b0;
    checks++;
    if (spr_bus_stb_o !== 1'b0 || spr_bus_we_o !== 1'b0 || resp_valid_o !== 1'b1 ||
        resp_dat_o !== '0 || resp_err_o !== 1'b0 || spr_bus_addr_o !== 16'h0800) begin
      errors++;
      $display("FAIL wr_resp got stb=%b we=%b rv=%b rd=%h re=%b addr=%h exp 0/0/1/0/0/0800",
               spr_bus_stb_o, spr_bus_we_o, resp_valid_o, resp_dat_o, resp_err_o, spr_bus_addr_o);
    end
    @(negedge clk);
    checks++;
    if (resp_valid_o !== 1'b0 || req_ready_o !== 1'b1) begin
      errors++;
      $display("FAIL wr_resp_end got rv=%b rdy=%b exp rv=0 rdy=1", resp_valid_o, req_ready_o);
    end
    $display("test_write_dmmu done");
  endtask

  task automatic test_read_ic_fast();
    dat_ic = 32'h12345678;
    issue(1'b0, 16'h2000, 32'hFFFF0000);
    checks++;
    if (spr_bus_stb_o !== 1'b1 || spr_bus_we_o !== 1'b0 || resp_valid_o !== 1'b0) begin
      errors++;
      $display("FAIL ic_first_stb got stb=%b we=%b rv=%b exp 1/0/0", spr_bus_stb_o, spr_bus_we_o, resp_valid_o);
    end
    ack_ic = 1'b1;
    @(negedge clk);
    ack_ic = 1'b0;
    checks++;
    if (resp_valid_o !== 1'b1 || resp_dat_o !== 32'h12345678 || resp_err_o !== 1'b0 || spr_bus_stb_o !== 1'b0) begin
      errors++;
      $display("FAIL ic_resp got rv=%b rd=%h re=%b stb=%b exp 1/12345678/0/0",
               resp_valid_o, resp_dat_o, resp_err_o, spr_bus_stb_o);
    end
    @(negedge clk);
    $display("test_read_ic_fast done");
  endtask

  task automatic test_unmapped();
    issue(1'b0, 16'h4000, 32'h0);
    checks++;
    if (resp_valid_o !== 1'b1 || resp_dat_o !== '0 || resp_err_o !== 1'b0 || spr_bus_stb_o !== 1'b0) begin
      errors++;
      $display("FAIL unmapped_resp got rv=%b rd=%h re=%b stb=%b exp 1/0/0/0",
               resp_valid_o, resp_dat_o, resp_err_o, spr_bus_stb_o);
    end
    @(negedge clk);
    checks++;
    if (resp_valid_o !== 1'b0 || spr_bus_stb_o !== 1'b0 || req_ready_o !== 1'b1) begin
      errors++;
      $display("FAIL unmapped_end got rv=%b stb=%b rdy=%b exp 0/0/1", resp_valid_o, spr_bus_stb_o, req_ready_o);
    end
    $display("test_unmapped done");
  endtask

  task automatic test_wrong_group_ack();
    dat_dc = 32'hCAFEF00D; dat_immu = 32'h11111111; dat_dmmu = 32'h22222222; dat_ic = 32'h33333333;
    issue(1'b0, 16'h1800, 32'h0);
    for (int i = 0; i < 6; i++) begin
      checks++;
      if (spr_bus_stb_o !== 1'b1 || resp_valid_o !== 1'b0 || spr_bus_addr_o !== 16'h1800) begin
        errors++;
        $display("FAIL wrong_ack_hold cyc=%0d got stb=%b rv=%b addr=%h exp 1/0/1800",
                 i, spr_bus_stb_o, resp_valid_o, spr_bus_addr_o);
      end
      ack_immu = (i == 0);
      ack_dmmu = (i == 2);
      ack_ic   = (i == 2);
      ack_dc   = (i == 5);
      @(negedge clk);
    end
    ack_immu = 1'b0; ack_dmmu = 1'b0; ack_ic = 1'b0; ack_dc = 1'b0;
    checks++;
    if (resp_valid_o !== 1'b1 || resp_dat_o !== 32'hCAFEF00D || resp_err_o !== 1'b0 || spr_bus_stb_o !== 1'b0) begin
      errors++;
      $display("FAIL wrong_ack_resp got rv=%b rd=%h re=%b stb=%b exp 1/cafef00d/0/0",
               resp_valid_o, resp_dat_o, resp_err_o, spr_bus_stb_o);
    end
    @(negedge clk);
    $display("test_wrong_group_ack done");
  endtask

  task automatic test_timeout();
    dat_dmmu = 32'hA5A5A5A5;
    issue(1'b0, 16'h0801, 32'h0);
    for (int i = 0; i < 8; i++) begin
      checks++;
      if (spr_bus_stb_o !== 1'b1 || resp_valid_o !== 1'b0) begin
        errors++;
        $display("FAIL timeout_stb cyc=%0d got stb=%b rv=%b exp 1/0", i, spr_bus_stb_o, resp_valid_o);
      end
      @(negedge clk);
    end
    checks++;
    if (spr_bus_stb_o !== 1'b0 || resp_valid_o !== 1'b1 || resp_err_o !== 1'b1 || resp_dat_o !== '0) begin
      errors++;
      $display("FAIL timeout_resp got stb=%b rv=%b re=%b rd=%h exp 0/1/1/0",
               spr_bus_stb_o, resp_valid_o, resp_err_o, resp_dat_o);
    end
    @(negedge clk);
    checks++;
    if (resp_valid_o !== 1'b0 || resp_err_o !== 1'b1 || spr_bus_stb_o !== 1'b0) begin
      errors++;
      $display("FAIL timeout_hold got rv=%b re=%b stb=%b exp 0/1/0", resp_valid_o, resp_err_o, spr_bus_stb_o);
    end
    // Follow-up write must see a fresh rising strobe and clear the error.
    req_valid_i = 1'b1; req_we_i = 1'b1; req_addr_i = 16'h0810; req_dat_i = 32'h0BADF00D;
    @(negedge clk);
    req_valid_i = 1'b0;
    checks++;
    if (spr_bus_stb_o !== 1'b1 || spr_bus_addr_o !== 16'h0810 || spr_bus_dat_o !== 32'h0BADF00D) begin
      errors++;
      $display("FAIL timeout_next_stb got stb=%b addr=%h dat=%h exp 1/0810/0badf00d",
               spr_bus_stb_o, spr_bus_addr_o, spr_bus_dat_o);
    end
    ack_dmmu = 1'b1;
    @(negedge clk);
    ack_dmmu = 1'b0;
    checks++;
    if (resp_valid_o !== 1'b1 || resp_err_o !== 1'b0 || resp_dat_o !== '0) begin
      errors++;
      $display("FAIL timeout_next_resp got rv=%b re=%b rd=%h exp 1/0/0", resp_valid_o, resp_err_o, resp_dat_o);
    end
    @(negedge clk);
    $display("test_timeout done");
  endtask

  task automatic test_reset_mid_cycle();
    issue(1'b1, 16'h1805, 32'h5555AAAA);
    checks++;
    if (spr_bus_stb_o !== 1'b1) begin
      errors++;
      $display("FAIL midrst_stb_before got=%b exp=1", spr_bus_stb_o);
    end
    rst = 1'b1;
    @(negedge clk);
    checks++;
    if (spr_bus_stb_o !== 1'b0 || resp_valid_o !== 1'b0 || spr_bus_we_o !== 1'b0 ||
        spr_bus_addr_o !== 16'h0 || req_ready_o !== 1'b0) begin
      errors++;
      $display("FAIL midrst_outputs got stb=%b rv=%b we=%b addr=%h rdy=%b exp 0/0/0/0000/0",
               spr_bus_stb_o, resp_valid_o, spr_bus_we_o, spr_bus_addr_o, req_ready_o);
    end
    rst = 1'b0;
    ack_dc = 1'b1;
    @(negedge clk);
    ack_dc = 1'b0;
    checks++;
    if (req_ready_o !== 1'b1 || resp_valid_o !== 1'b0 || spr_bus_stb_o !== 1'b0) begin
      errors++;
      $display("FAIL midrst_after got rdy=%b rv=%b stb=%b exp 1/0/0", req_ready_o, resp_valid_o, spr_bus_stb_o);
    end
    @(negedge clk);
    checks++;
    if (resp_valid_o !== 1'b0) begin
      errors++;
      $display("FAIL midrst_no_resp got rv=%b exp 0", resp_valid_o);
    end
    $display("test_reset_mid_cycle done");
  endtask

  initial begin
    rst = 1'b1;
    req_valid_i = 1'b0; req_we_i = 1'b0; req_addr_i = '0; req_dat_i = '0;
    ack_dmmu = 1'b0; ack_immu = 1'b0; ack_dc = 1'b0; ack_ic = 1'b0;
    dat_dmmu = '0; dat_immu = '0; dat_dc = '0; dat_ic = '0;
    test_reset();
    test_write_dmmu();
    test_read_ic_fast();
    test_unmapped();
    test_wrong_group_ack();
    test_timeout();
    test_reset_mid_cycle();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/spr_bus_access_ctrl.md
Name: spr_bus_access_ctrl

Overview:
- Upstream master of the SPR bus: turns single mtspr/mfspr requests from the execute/control stage into SPR bus cycles to the DMMU, IMMU, DC and IC group slaves.
- Holds strobe, address, write-enable and data stable until the addressed group acks, then returns the read data or completion status.
- Unmapped groups complete locally without a bus cycle.
- A watchdog terminates cycles that are never acked.

Parameters:
OPTION_OPERAND_WIDTH, 32, width of SPR data.
OPTION_SPR_TIMEOUT, 64, cycles without ack before the cycle is aborted; 0 disables the watchdog.

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
req_valid_i  in  1  SPR access request
req_we_i  in  1  1=mtspr write, 0=mfspr read
req_addr_i  in  16  SPR address; group = addr[15:11]
req_dat_i  in  OPTION_OPERAND_WIDTH  write data
req_ready_o  out  1  request accepted this cycle when high with req_valid_i
resp_valid_o  out  1  one-cycle completion pulse
resp_dat_o  out  OPTION_OPERAND_WIDTH  read data; 0 for writes, unmapped groups and errors
resp_err_o  out  1  watchdog abort
spr_bus_addr_o  out  16  bus address
spr_bus_we_o  out  1  bus write enable
spr_bus_stb_o  out  1  bus strobe
spr_bus_dat_o  out  OPTION_OPERAND_WIDTH  bus write data
spr_bus_ack_dmmu_i, spr_bus_ack_immu_i, spr_bus_ack_dc_i, spr_bus_ack_ic_i  in  1 each  slave acks
spr_bus_dat_dmmu_i, spr_bus_dat_immu_i, spr_bus_dat_dc_i, spr_bus_dat_ic_i  in  OPTION_OPERAND_WIDTH each  slave read data

Behaviour:
- Reset: spr_bus_stb_o=0, spr_bus_we_o=0, spr_bus_addr_o=0, spr_bus_dat_o=0, resp_valid_o=0, resp_dat_o=0, resp_err_o=0. State=IDLE. Watchdog counter=0.
- Group decode: 1=DMMU, 2=IMMU, 3=DC, 4=IC. Any other group is unmapped.
- req_ready_o = (state==IDLE) & !rst. It is combinational from state. Requests arriving while not ready are ignored; the requester holds req_valid_i.
- IDLE, accept on a mapped group:
  - Latch addr, we and dat into the bus registers.
  - Next cycle spr_bus_stb_o=1; state=BUS. The selected group is captured in a one-hot register.
- IDLE, accept on an unmapped group:
  - No strobe.
  - Next cycle resp_valid_o=1, resp_dat_o=0, resp_err_o=0; state=RESP.
- BUS:
  - addr, we, dat and stb are held constant every cycle until termination.
  - Only the ack of the selected group completes the cycle. Acks from other groups are ignored, including simultaneous multiple acks.
  - Selected ack high with stb high: next cycle stb=0 and resp_valid_o=1. For reads, resp_dat_o = that group's data sampled in the ack cycle; for writes, resp_dat_o=0. resp_err_o=0. state=RESP.
  - An ack in the same cycle stb first rises counts. Minimum latency is request accept to resp_valid_o = 2 cycles.
- Watchdog:
  - Counts BUS cycles and is cleared on entry to BUS.
  - When the count reaches OPTION_SPR_TIMEOUT-1 without the selected ack: next cycle stb=0, resp_valid_o=1, resp_err_o=1, resp_dat_o=0; state=RESP.
  - If ack and timeout coincide, the ack wins.
- RESP:
  - resp_valid_o is high exactly one cycle; the response must be consumed that cycle.
  - Next cycle state=IDLE, resp_valid_o=0. resp_dat_o and resp_err_o hold their values until the next response.
- Strobe spacing: stb is low for at least 2 cycles (RESP, IDLE-accept) between bus cycles, so every new cycle produces a rising strobe.
- Bus registers keep their last values while stb=0. spr_bus_we_o is cleared when stb drops.
- Reset mid-operation: on the reset cycle all outputs return to reset values. No response is produced for the aborted request.

Test Plan:
- Write to DMMU: req we=1, addr=0x0800, dat=0xDEADBEEF; ack_dmmu 3 cycles after stb rises -> stb high 4 cycles with addr and we stable; resp_valid 1 cycle later with dat=0, err=0.
- Read from IC: addr=0x2000, ack_ic in the first stb cycle with dat_ic=0x12345678 -> resp_valid 2 cycles after accept, resp_dat=0x12345678.
- Unmapped group 8, addr=0x4000 -> stb never asserts; resp_valid next cycle, resp_dat=0, err=0.
- Wrong-group ack: DC read (addr=0x1800) with ack_immu pulsed, ack_dc after 5 cycles -> completes only on ack_dc; resp_dat = dat_dc.
- Timeout: OPTION_SPR_TIMEOUT=8, DMMU access never acked -> stb high exactly 8 cycles; resp_valid with err=1, dat=0. A following request gets a fresh rising stb.
- Reset mid-cycle: assert rst during BUS -> stb=0 next edge, no resp_valid. req_ready_o=1 after rst deasserts.
